// File: rtl/seq_signed_or_unsigned_mul_pkg.sv
// Shared types and helpers for the iterative shift-add signed/unsigned multiplier.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must hold values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_signed_or_unsigned_mul_if.sv
// Argument and result valid/ready ports of the sequential multiplier.
interface seq_signed_or_unsigned_mul_if #(
  parameter int N = 8
);
  logic           arg_vld;
  logic           arg_rdy;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           signed_mul;
  logic           res_vld;
  logic           res_rdy;
  logic [2*N-1:0] res;

  modport master (
    output arg_vld, a, b, signed_mul, res_rdy,
    input  arg_rdy, res_vld, res
  );

  modport slave (
    input  arg_vld, a, b, signed_mul, res_rdy,
    output arg_rdy, res_vld, res
  );
endinterface

// File: rtl/seq_signed_or_unsigned_mul_abs.sv
// Operand magnitude/sign split; in signed mode -2^(n-1) maps to the unsigned 2^(n-1).
module seq_mul_abs #(
  parameter int n = 8
) (
  input  logic [n-1:0] x,
  input  logic         signed_mul,
  output logic [n-1:0] mag,
  output logic         sign
);

  assign sign = signed_mul & x[n-1];
  assign mag  = sign ? -x : x;

endmodule

// File: rtl/seq_signed_or_unsigned_mul.sv
// Iterative shift-add n x n -> 2n multiplier, signed or unsigned per operation.
// Define SEQ_MUL_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module seq_signed_or_unsigned_mul
  import seq_mul_pkg::*;
#(
  parameter int n = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  seq_signed_or_unsigned_mul_if.slave   bus
);

  localparam int CW = cnt_width(n);

  state_t          r_state;
  logic [2*n-1:0]  r_mcand;
  logic [n-1:0]    r_mplier;
  logic [2*n-1:0]  r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_neg;
  logic [2*n-1:0]  r_res;

  logic [n-1:0]    w_a_mag;
  logic [n-1:0]    w_b_mag;
  logic            w_a_sign;
  logic            w_b_sign;
  logic            w_accept;
  logic [2*n-1:0]  w_acc_next;
  logic [n-1:0]    w_mplier_next;
  logic [2*n-1:0]  w_final;
  logic            w_last;

  seq_mul_abs #(.n(n)) u_abs_a (
    .x          (bus.a),
    .signed_mul (bus.signed_mul),
    .mag        (w_a_mag),
    .sign       (w_a_sign)
  );

  seq_mul_abs #(.n(n)) u_abs_b (
    .x          (bus.b),
    .signed_mul (bus.signed_mul),
    .mag        (w_b_mag),
    .sign       (w_b_sign)
  );

  assign bus.arg_rdy = (r_state == IDLE) | ((r_state == DONE) & bus.res_rdy);
  assign bus.res_vld = (r_state == DONE);
  assign bus.res     = r_res;
  assign w_accept    = bus.arg_vld & bus.arg_rdy;

  assign w_acc_next    = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mplier_next = r_mplier >> 1;
  assign w_final       = r_neg ? -w_acc_next : w_acc_next;

`ifdef SEQ_MUL_EARLY_TERM_EN
  // Once the remaining multiplier bits are zero no further additions can change the sum.
  assign w_last = (w_mplier_next == '0) || (r_cnt == CW'(n - 1));
`else
  assign w_last = (r_cnt == CW'(n - 1));
`endif

  // NOTE: state is updated only with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_res    <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_mcand  <= {{n{1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
            r_neg    <= w_a_sign ^ w_b_sign;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= BUSY;
          end else if ((r_state == DONE) && bus.res_rdy) begin
            r_state <= IDLE;
          end
        end
        BUSY: begin
          r_acc    <= w_acc_next;
          r_mplier <= w_mplier_next;
          r_mcand  <= r_mcand << 1;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_res   <= w_final;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_or_unsigned_mul.sv
// Scoreboard bench for seq_signed_or_unsigned_mul at n=8, latency-aware in both builds.
module tb_seq_signed_or_unsigned_mul;

  typedef struct {
    logic [15:0] res;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  seq_signed_or_unsigned_mul_if #(.N(8)) bus ();

  seq_signed_or_unsigned_mul #(.n(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
    int p;
    if (s) p = int'(signed'(a)) * int'(signed'(b));
    else   p = int'(a) * int'(b);
    return p[15:0];
  endfunction

  function automatic int exp_latency(input logic [7:0] b, input logic s);
`ifdef SEQ_MUL_EARLY_TERM_EN
    logic [7:0] m;
    int l;
    m = (s && b[7]) ? -b : b;
    l = 1;
    for (int i = 0; i < 8; i++) if (m[i]) l = i + 1;
    return l;
`else
    return 8;
`endif
  endfunction

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [15:0] exp_res, input string name);
    exp_t e;
    int   w;
    w = 0;
    bus.a = a;
    bus.b = b;
    bus.signed_mul = s;
    bus.arg_vld = 1'b1;
    #1;
    while (!bus.arg_rdy && w < 50) begin
      @(negedge clk);
      #1;
      w++;
    end
    checks++;
    if (bus.arg_rdy !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: arg_rdy=%b required 1", name, bus.arg_rdy);
    end
    e.res = exp_res;
    e.lat = exp_latency(b, s);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bus.arg_vld = 1'b0;
    bus.a = ~a;
    bus.b = ~b;
    bus.signed_mul = ~s;
  endtask

  task automatic collect(input string name);
    exp_t e;
    int   lat;
    lat = 0;
    while (!bus.res_vld && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (bus.res_vld !== 1'b1) begin
      errors++;
      $display("FAIL %s res_vld timeout: res_vld=%b required 1", name, bus.res_vld);
    end
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      checks++;
      if (bus.res !== e.res) begin
        errors++;
        $display("FAIL %s res: got %h required %h", name, bus.res, e.res);
      end
      checks++;
      if (lat != e.lat) begin
        errors++;
        $display("FAIL %s latency: got %0d required %0d", name, lat, e.lat);
      end
    end
  endtask

  task automatic release_res(input string name);
    bus.res_rdy = 1'b1;
    @(negedge clk);
    bus.res_rdy = 1'b0;
    #1;
    checks++;
    if (bus.res_vld !== 1'b0 || bus.arg_rdy !== 1'b1) begin
      errors++;
      $display("FAIL %s release: res_vld=%b arg_rdy=%b required 0/1", name, bus.res_vld, bus.arg_rdy);
    end
  endtask

  task automatic op(input logic [7:0] a, input logic [7:0] b, input logic s,
                    input logic [15:0] exp_res, input string name);
    send(a, b, s, exp_res, name);
    collect(name);
    release_res(name);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (bus.res_vld !== 1'b0 || bus.res !== 16'h0 || bus.arg_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset: res_vld=%b res=%h arg_rdy=%b required 0/0000/1",
               bus.res_vld, bus.res, bus.arg_rdy);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    op(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u255x255");
    op(8'hFD, 8'h05, 1'b1, 16'hFFF1, "s-3x5");
    op(8'hFD, 8'h05, 1'b0, 16'h04F1, "u253x5");
    op(8'h80, 8'h80, 1'b1, 16'h4000, "s-128x-128");
    op(8'h80, 8'h01, 1'b1, 16'hFF80, "s-128x1");
    op(8'h05, 8'hFD, 1'b1, 16'hFFF1, "s5x-3");
  endtask

  task automatic test_early_term();
    op(8'd200, 8'd1,   1'b0, 16'd200,   "u200x1");
    op(8'd200, 8'd0,   1'b0, 16'd0,     "u200x0");
    op(8'd200, 8'd128, 1'b0, 16'd25600, "u200x128");
    op(8'h7F,  8'hFF,  1'b1, 16'hFF81,  "s127x-1");
  endtask

  task automatic test_back_to_back();
    send(8'hFD, 8'h05, 1'b1, 16'hFFF1, "bp_first");
    collect("bp_first");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.res_vld !== 1'b1 || bus.res !== 16'hFFF1 || bus.arg_rdy !== 1'b0) begin
        errors++;
        $display("FAIL backpressure hold %0d: res_vld=%b res=%h arg_rdy=%b required 1/fff1/0",
                 i, bus.res_vld, bus.res, bus.arg_rdy);
      end
    end
    bus.res_rdy = 1'b1;
    #1;
    checks++;
    if (bus.arg_rdy !== 1'b1) begin
      errors++;
      $display("FAIL b2b arg_rdy: got %b required 1", bus.arg_rdy);
    end
    send(8'hFD, 8'h05, 1'b0, 16'h04F1, "bp_second");
    bus.res_rdy = 1'b0;
    #1;
    checks++;
    if (bus.res_vld !== 1'b0) begin
      errors++;
      $display("FAIL b2b busy: res_vld=%b required 0", bus.res_vld);
    end
    collect("bp_second");
    release_res("bp_second");
  endtask

  task automatic test_mid_reset();
    send(8'hFF, 8'hFF, 1'b0, 16'hFE01, "abort");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.res_vld !== 1'b0 || bus.res !== 16'h0 || bus.arg_rdy !== 1'b1) begin
      errors++;
      $display("FAIL mid reset: res_vld=%b res=%h arg_rdy=%b required 0/0000/1",
               bus.res_vld, bus.res, bus.arg_rdy);
    end
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (bus.res_vld !== 1'b0) begin
        errors++;
        $display("FAIL aborted result shown: res_vld=%b required 0", bus.res_vld);
      end
    end
    op(8'd7, 8'd6, 1'b0, 16'd42, "u7x6");
  endtask

  task automatic test_random();
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    for (int i = 0; i < 8; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      s = 1'($urandom);
      op(a, b, s, model(a, b, s), $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    bus.arg_vld = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.signed_mul = 1'b0;
    bus.res_rdy = 1'b0;
    test_reset();
    test_directed();
    test_early_term();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
